// File: rtl/sort_host_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_host_ctrl : operand fill buffer, PS sequencing and sorted-stream capture
// Revision 1.0
// ---------------------------------------------------------------------------
module sort_host_ctrl #(
  parameter int N        = 5,
  parameter int bitwidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [bitwidth-1:0] in_data,
  output logic                in_ready,
  output logic                run,
  output logic [2:0]          PS,
  output logic [bitwidth-1:0] val_in,
  input  logic [7:0]          addr,
  input  logic [bitwidth-1:0] val_out,
  input  logic                end_load,
  input  logic                hit_i,
  input  logic                hit_j,
  input  logic                end_show,
  output logic                out_valid,
  output logic [bitwidth-1:0] out_data,
  output logic [3:0]          out_index,
  output logic                busy,
  output logic                done,
  output logic                sort_err
);

  localparam logic [3:0] c_n_cnt  = 4'(N);
  localparam logic [7:0] c_n_addr = 8'(N);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_LOAD    = 3'd2,
    S_ANCHOR  = 3'd3,
    S_FINDMIN = 3'd4,
    S_SHOW    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                first_q;
  logic [3:0]          cnt_q;
  logic [bitwidth-1:0] buf_q [16];
  logic                cap_q;
  logic [3:0]          cap_cnt_q;
  logic                out_valid_q;
  logic [bitwidth-1:0] out_data_q;
  logic [3:0]          out_index_q;
  logic                sort_err_q;
  logic                fill_hs;
  logic                job_start;

  assign job_start = (state_q == S_IDLE) && start;
  assign in_ready  = (state_q == S_FILL) && (cnt_q < c_n_cnt);
  assign fill_hs   = in_ready && in_valid;

  // Datapath flags are registered one cycle behind PS, so the first cycle of
  // every PS state sees stale values and must not act on them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_FILL;
      S_FILL:    if (cnt_q == c_n_cnt) state_d = S_LOAD;
      S_LOAD:    if (!first_q && end_load) state_d = S_ANCHOR;
      S_ANCHOR:  if (!first_q) state_d = hit_i ? S_SHOW : S_FINDMIN;
      S_FINDMIN: if (!first_q && hit_j) state_d = S_ANCHOR;
      S_SHOW:    if (!first_q && end_show) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PS = 3'd0;
    unique case (state_q)
      S_LOAD:    PS = 3'd1;
      S_ANCHOR:  PS = 3'd2;
      S_FINDMIN: PS = 3'd3;
      S_SHOW:    PS = 3'd4;
      default:   PS = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
    end
  end

  // Buffer is not reset: contents survive between jobs until refilled.
  always_ff @(posedge clk) begin
    if (fill_hs) begin
      buf_q[cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      cap_q       <= 1'b0;
      cap_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= 4'd0;
      sort_err_q  <= 1'b0;
    end else begin
      cap_q       <= (state_q == S_SHOW) && (addr < c_n_addr);
      out_valid_q <= cap_q;
      if (job_start) begin
        cnt_q       <= 4'd0;
        cap_cnt_q   <= 4'd0;
        out_index_q <= 4'd0;
        sort_err_q  <= 1'b0;
      end
      if (fill_hs) begin
        cnt_q <= cnt_q + 4'd1;
      end
      // val_out here answers the address presented on the previous cycle.
      if (cap_q) begin
        out_data_q  <= val_out;
        out_index_q <= cap_cnt_q;
        cap_cnt_q   <= cap_cnt_q + 4'd1;
        if ((cap_cnt_q != 4'd0) && (val_out < out_data_q)) begin
          sort_err_q <= 1'b1;
        end
      end
    end
  end

  assign val_in    = ((state_q == S_LOAD) && (addr < c_n_addr)) ? buf_q[addr[3:0]] : '0;
  assign run       = (PS != 3'd0);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign sort_err  = sort_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_host_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sort_host_ctrl : directed bench with a simple selection-sort datapath model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sort_host_ctrl;

  localparam int N = 5;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         run;
  logic [2:0]   PS;
  logic [W-1:0] val_in;
  logic [7:0]   addr;
  logic [W-1:0] val_out  = '0;
  logic         end_load = 1'b0;
  logic         hit_i    = 1'b0;
  logic         hit_j    = 1'b0;
  logic         end_show = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_index;
  logic         busy;
  logic         done;
  logic         sort_err;

  always #5 clk = ~clk;

  sort_host_ctrl #(.N(N), .bitwidth(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .run       (run),
    .PS        (PS),
    .val_in    (val_in),
    .addr      (addr),
    .val_out   (val_out),
    .end_load  (end_load),
    .hit_i     (hit_i),
    .hit_j     (hit_j),
    .end_show  (end_show),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done),
    .sort_err  (sort_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- datapath model ----------------
  logic [7:0][W-1:0] vals;
  logic [7:0][W-1:0] exp_ok;
  logic [7:0][W-1:0] bad_seq;
  logic [7:0][W-1:0] mem_q = '0;
  logic [7:0][W-1:0] seq_q = '0;
  logic [2:0] ps_last_q = 3'd0;
  int         ctr_q     = 0;
  int         anchors_q = 0;
  int         m_cyc;
  logic       m_entry;
  bit         inj_load  = 1'b0;
  bit         inj_j     = 1'b0;
  bit         bad_order = 1'b0;

  function automatic logic [7:0][W-1:0] sorted(input logic [7:0][W-1:0] m);
    logic [7:0][W-1:0] r;
    logic [W-1:0]      t;
    r = m;
    for (int a = 1; a < N; a++) begin
      for (int b = a; b > 0; b--) begin
        if (r[b-1] > r[b]) begin
          t = r[b]; r[b] = r[b-1]; r[b-1] = t;
        end
      end
    end
    return r;
  endfunction

  assign m_entry = (PS != ps_last_q);
  assign m_cyc   = m_entry ? 0 : ctr_q;
  assign addr    = (m_cyc >= N) ? 8'(N) : 8'(m_cyc);

  always @(posedge clk) begin
    ps_last_q <= rst ? 3'd0 : PS;
    ctr_q     <= rst ? 0 : m_cyc + 1;
    if (PS == 3'd1) anchors_q <= 0;
    else if (PS == 3'd2 && m_entry) anchors_q <= anchors_q + 1;
    if (PS == 3'd1 && m_cyc < N) mem_q[m_cyc[2:0]] <= val_in;
    if (PS == 3'd1 && m_cyc == N) seq_q <= bad_order ? bad_seq : sorted(mem_q);
    end_load <= inj_load || (PS == 3'd1 && m_cyc >= N);
    hit_i    <= (PS == 3'd2) && m_entry && (anchors_q == N-1);
    hit_j    <= (PS == 3'd3 && m_cyc >= 2) || (inj_j && PS == 3'd2);
    end_show <= (PS == 3'd4) && (m_cyc >= N+1);
    val_out  <= (PS == 3'd4 && m_cyc < N) ? seq_q[m_cyc[2:0]] : '0;
  end

  // ---------------- monitor ----------------
  int cyc_n = 0;
  int load_len, fm_len, fm_min, fm_cnt, n_out, last_out_cyc, first_out_cyc;
  int show_cyc, done_cnt, done_cyc, gap_bad;
  logic done_err;
  logic [7:0][W-1:0] od;
  logic [7:0][3:0]   oi;
  logic [7:0]        se;
  logic [2:0]        ps_prev_m = 3'd0;

  task automatic clear_mon();
    load_len = 0; fm_len = 0; fm_min = 999; fm_cnt = 0; n_out = 0;
    last_out_cyc = 0; first_out_cyc = 0; show_cyc = 0; done_cnt = 0;
    done_cyc = 0; gap_bad = 0; done_err = 1'b0; od = '0; oi = '0; se = '0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      cyc_n++;
      if (PS == 3'd1) begin
        load_len++;
        if (addr < N) check_eq($sformatf("val_in[%0d]", addr), val_in, vals[addr[2:0]]);
      end
      if (PS == 3'd3) fm_len++;
      else if (fm_len > 0) begin
        fm_cnt++;
        if (fm_len < fm_min) fm_min = fm_len;
        fm_len = 0;
      end
      if (PS == 3'd4 && ps_prev_m != 3'd4) show_cyc = cyc_n;
      if (out_valid) begin
        if (n_out > 0 && cyc_n != last_out_cyc + 1) gap_bad++;
        if (n_out == 0) first_out_cyc = cyc_n;
        if (n_out < 8) begin
          od[n_out] = out_data;
          oi[n_out] = out_index;
          se[n_out] = sort_err;
        end
        n_out++;
        last_out_cyc = cyc_n;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
        done_err = sort_err;
      end
      ps_prev_m = PS;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs();
    check_eq("rst_PS", PS, 0);
    check_eq("rst_run", run, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sort_err", sort_err, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_index", out_index, 0);
    check_eq("rst_val_in", val_in, 0);
  endtask

  task automatic run_job(input bit bad, input bit poke_start);
    int hs, idx;
    bit chk_drop, poke;
    logic [7:0][W-1:0] exp;
    bad_order = bad;
    inj_load  = 1'b1;
    inj_j     = 1'b1;
    exp       = bad ? bad_seq : exp_ok;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hs = 0; idx = 0; chk_drop = 1'b0;
    for (int k = 0; k < 60 && PS != 3'd1; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = (idx < N) ? vals[idx[2:0]] : 8'hEE;
      #1;
      if (in_valid && in_ready) begin
        hs++;
        idx++;
      end
      @(negedge clk);
      if (hs == N && !chk_drop) begin
        check_eq("in_ready_drop", in_ready, 0);
        chk_drop = 1'b1;
      end
    end
    inj_load = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    check_eq("fill_handshakes", hs, N);
    check_eq("ps_load", PS, 1);
    check_eq("in_ready_in_load", in_ready, 0);
    poke = poke_start;
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      @(negedge clk); #1;
      if (poke && PS == 3'd4) begin
        start = 1'b1;
        poke  = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    inj_j    = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_eq("load_len", load_len, N + 2);
    check_eq("findmin_dwell", (fm_min >= 2), 1);
    check_eq("findmin_visits", fm_cnt, N - 1);
    check_eq("n_out", n_out, N);
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("out_data[%0d]", k), od[k], exp[k]);
      check_eq($sformatf("out_index[%0d]", k), oi[k], k);
    end
    check_eq("out_gap", gap_bad, 0);
    check_eq("first_out_lat", first_out_cyc - show_cyc, 2);
    check_eq("done_lat", done_cyc - last_out_cyc, 2);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("idle_PS", PS, 0);
    check_eq("idle_busy", busy, 0);
    if (bad) begin
      check_eq("err_idx1", se[1], 0);
      check_eq("err_idx2", se[2], 1);
      check_eq("err_at_done", done_err, 1);
    end else begin
      check_eq("err_at_done", done_err, 0);
    end
  endtask

  initial begin
    vals    = {8'd0, 8'd0, 8'd0, 8'd9, 8'd1, 8'd8, 8'd3, 8'd5};
    exp_ok  = {8'd0, 8'd0, 8'd0, 8'd9, 8'd8, 8'd5, 8'd3, 8'd1};
    bad_seq = {8'd0, 8'd0, 8'd0, 8'd9, 8'd8, 8'd3, 8'd5, 8'd1};
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Abort a job mid-FILL after two operands.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    check_eq("fill_busy", busy, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);

    run_job(1'b0, 1'b0);
    run_job(1'b1, 1'b1);

    check_eq("err_hold_idle", sort_err, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_clear_start", sort_err, 0);
    check_eq("restart_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
